ldpc_edge_sequencer: RTL and testbench
======================================

Name: ldpc_edge_sequencer

Overview:
Parametrised successor to the 2-bit up counter used by the min-sum check-node unit. Steps an edge index from 0 to a programmable last index once per decoding iteration and flags the edge whose index matches the latched min_index, so the datapath substitutes the second minimum there. Also counts iterations up to a programmable limit, honours an early-stop request at iteration boundaries, and supports a stall input. Sits between the decoder control FSM and the check-node min/second-min datapath.

Parameters:
IDX_W, 2, width of edge index, degree and min_index; max check degree is 2^IDX_W.
ITER_W, 4, width of iteration counter and max_iter.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a new decode; honoured only in IDLE
degree_m1  input  IDX_W  last edge index (degree-1); sampled on accepted start
min_index  input  IDX_W  index of the minimum-magnitude edge; sampled on accepted start
max_iter  input  ITER_W  iteration limit; sampled on accepted start; 0 is treated as 1
hold  input  1  stall: freezes count, iter and state while high
early_stop  input  1  syndrome-satisfied request; sampled only on a wrap cycle
count  output  IDX_W  current edge index (registered)
iter  output  ITER_W  completed-iteration count (registered)
busy  output  1  high in RUN
last_edge  output  1  busy && count==deg_lat
use_second_min  output  1  busy && count==min_lat
iter_done  output  1  one-cycle pulse after each non-final wrap
done  output  1  one-cycle pulse in DONE state

Behaviour:
- Reset (async, any time, including mid-RUN): state=IDLE; count, iter, latches, iter_done, done, busy = 0. Outputs return to 0 immediately and stay there until the first post-reset edge.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge latches deg_lat=degree_m1, min_lat=min_index, lim_lat=(max_iter==0 ? 1 : max_iter); count=0, iter=0; next state RUN. busy is high from the following cycle. start=0: remain in IDLE.
- RUN, hold=1: no register changes. iter_done and done are 0. early_stop is ignored.
- RUN, hold=0, count!=deg_lat: count<=count+1.
- RUN, hold=0, count==deg_lat (wrap cycle): count<=0 and iter<=iter+1.
  - If iter+1==lim_lat or early_stop==1: next state DONE.
  - Otherwise: stay in RUN; iter_done=1 in the next cycle only.
- DONE: done=1 and busy=0 for exactly one cycle. count holds 0; iter holds the final value. Next state IDLE. iter keeps its value in IDLE until the next accepted start.
- start in RUN or DONE is ignored. Input changes after the start edge have no effect.
- deg_lat=0: every RUN cycle is a wrap cycle; last_edge stays high throughout RUN.
- min_lat>deg_lat: use_second_min never asserts. This is legal.
- iter never exceeds lim_lat, so no wrap-around of iter occurs.
- Combinational outputs: last_edge and use_second_min are decoded from registered state only. No input-to-output paths.
- All arithmetic is unsigned, modulo the declared widths.

Test Plan:
- Reset mid-run: IDX_W=2, degree_m1=3, min_index=3, max_iter=2; start pulse.
  - Expect count 0,1,2,3,0,1,2,3; use_second_min high at count=3; iter_done one cycle after the first wrap.
  - Expect done one cycle after the second wrap, with iter=2.
  - Then assert reset mid-way through a fresh run: all outputs go to 0 asynchronously and the state is IDLE.
- Early stop: degree_m1=2, max_iter=5, early_stop=1 held from the start.
  - Expect count 0,1,2 then DONE with iter=1; no iter_done pulse.
  - Repeat with early_stop=1 only in a non-wrap cycle: expect no early termination.
- Hold: degree_m1=3; assert hold for 3 cycles while count=1.
  - count, iter, last_edge and use_second_min stay frozen.
  - Hold asserted on a wrap cycle with early_stop=1 does not terminate; resume and wrap normally.
- Degree-1 and max_iter=0: degree_m1=0, max_iter=0.
  - Expect busy for 1 cycle with last_edge=1 and count=0, then done with iter=1.
- Ignored start and out-of-range min_index: pulse start while busy, and change degree_m1 and min_index mid-run.
  - Sequence is unaffected.
  - With min_index=3 and degree_m1=1, use_second_min never asserts.
- Parametrised width: IDX_W=4, ITER_W=3, degree_m1=15, min_index=9, max_iter=7.
  - Expect 7 full 16-cycle sweeps; use_second_min asserts once per sweep.
  - Expect iter_done 6 times, then done with iter=7.

Source files
------------

// File: rtl/ldpc_edge_sequencer.sv
// Edge-index sequencer for the min-sum check-node unit: sweeps edges once per
// iteration, flags the min edge for second-min substitution, and counts iterations.
module ldpc_edge_sequencer #(
  parameter int IDX_W  = 2,
  parameter int ITER_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  degree_m1,
  input  logic [IDX_W-1:0]  min_index,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              hold,
  input  logic              early_stop,
  output logic [IDX_W-1:0]  count,
  output logic [ITER_W-1:0] iter,
  output logic              busy,
  output logic              last_edge,
  output logic              use_second_min,
  output logic              iter_done,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [IDX_W-1:0]  IDX_ZERO  = IDX_W'(0);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [ITER_W-1:0] ITER_ZERO = ITER_W'(0);
  localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);

  state_t             state_r;
  logic [IDX_W-1:0]   count_r;
  logic [ITER_W-1:0]  iter_r;
  logic [IDX_W-1:0]   deg_lat_r;
  logic [IDX_W-1:0]   min_lat_r;
  logic [ITER_W-1:0]  lim_lat_r;
  logic               busy_r;
  logic               iter_done_r;
  logic               done_r;

  logic [ITER_W-1:0]  iter_inc_s;
  logic               wrap_s;
  logic               final_s;

  // Wrap and termination decode from registered state plus the early-stop request
  always_comb begin
    iter_inc_s = iter_r + ITER_ONE;
    wrap_s     = (count_r == deg_lat_r);
    if ((iter_inc_s == lim_lat_r) || early_stop) begin
      final_s = 1'b1;
    end else begin
      final_s = 1'b0;
    end
  end

  // Sequencer state machine with registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      count_r     <= IDX_ZERO;
      iter_r      <= ITER_ZERO;
      deg_lat_r   <= IDX_ZERO;
      min_lat_r   <= IDX_ZERO;
      lim_lat_r   <= ITER_ZERO;
      busy_r      <= 1'b0;
      iter_done_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          iter_done_r <= 1'b0;
          done_r      <= 1'b0;
          if (start) begin
            deg_lat_r <= degree_m1;
            min_lat_r <= min_index;
            // A zero limit still runs one full iteration
            lim_lat_r <= (max_iter == ITER_ZERO) ? ITER_ONE : max_iter;
            count_r   <= IDX_ZERO;
            iter_r    <= ITER_ZERO;
            busy_r    <= 1'b1;
            state_r   <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          done_r <= 1'b0;
          if (hold) begin
            iter_done_r <= 1'b0;
          end else if (!wrap_s) begin
            count_r     <= count_r + IDX_ONE;
            iter_done_r <= 1'b0;
          end else begin
            count_r <= IDX_ZERO;
            iter_r  <= iter_inc_s;
            if (final_s) begin
              iter_done_r <= 1'b0;
              done_r      <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= DONE;
            end else begin
              iter_done_r <= 1'b1;
            end
          end
        end
        DONE: begin
          iter_done_r <= 1'b0;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          count_r     <= IDX_ZERO;
          iter_r      <= ITER_ZERO;
          busy_r      <= 1'b0;
          iter_done_r <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign count          = count_r;
  assign iter           = iter_r;
  assign busy           = busy_r;
  assign iter_done      = iter_done_r;
  assign done           = done_r;
  assign last_edge      = busy_r && (count_r == deg_lat_r);
  assign use_second_min = busy_r && (count_r == min_lat_r);

endmodule

// File: tb/tb_ldpc_edge_sequencer.sv
// Directed self-checking bench for ldpc_edge_sequencer (default and wide parameter sets).
module tb_ldpc_edge_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] degree_m1;
  logic [1:0] min_index;
  logic [3:0] max_iter;
  logic       hold;
  logic       early_stop;
  logic [1:0] count;
  logic [3:0] iter;
  logic       busy, last_edge, use_second_min, iter_done, done;

  logic       p_start;
  logic [3:0] p_degree_m1, p_min_index;
  logic [2:0] p_max_iter;
  logic [3:0] p_count;
  logic [2:0] p_iter;
  logic       p_busy, p_last_edge, p_use_second_min, p_iter_done, p_done;

  int checks = 0;
  int failures = 0;

  ldpc_edge_sequencer #(.IDX_W(2), .ITER_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .degree_m1(degree_m1),
    .min_index(min_index), .max_iter(max_iter), .hold(hold), .early_stop(early_stop),
    .count(count), .iter(iter), .busy(busy), .last_edge(last_edge),
    .use_second_min(use_second_min), .iter_done(iter_done), .done(done)
  );

  ldpc_edge_sequencer #(.IDX_W(4), .ITER_W(3)) dut_wide (
    .clk(clk), .reset(reset), .start(p_start), .degree_m1(p_degree_m1),
    .min_index(p_min_index), .max_iter(p_max_iter), .hold(1'b0), .early_stop(1'b0),
    .count(p_count), .iter(p_iter), .busy(p_busy), .last_edge(p_last_edge),
    .use_second_min(p_use_second_min), .iter_done(p_iter_done), .done(p_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int c, input int it, input int b,
                           input int le, input int usm, input int id, input int d);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".iter"}, 32'(iter), 32'(it));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".last_edge"}, 32'(last_edge), 32'(le));
    check({tag, ".use_second_min"}, 32'(use_second_min), 32'(usm));
    check({tag, ".iter_done"}, 32'(iter_done), 32'(id));
    check({tag, ".done"}, 32'(done), 32'(d));
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check_all("reset_async", 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic do_start(input logic [1:0] dm1, input logic [1:0] mi, input logic [3:0] mx);
    degree_m1 = dm1;
    min_index = mi;
    max_iter  = mx;
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int usm_cnt;
    int idn_cnt;
    reset = 1'b1; start = 1'b0; degree_m1 = 2'd0; min_index = 2'd0; max_iter = 4'd0;
    hold = 1'b0; early_stop = 1'b0;
    p_start = 1'b0; p_degree_m1 = 4'd0; p_min_index = 4'd0; p_max_iter = 3'd0;
    #12;
    check_all("por", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    check_all("idle", 0, 0, 0, 0, 0, 0, 0);

    // Two full sweeps of a degree-4 check node, min at the last edge
    do_start(2'd3, 2'd3, 4'd2);
    for (int i = 0; i < 8; i++) begin
      check_all($sformatf("run1_%0d", i), i % 4, i / 4, 1, (i % 4 == 3) ? 1 : 0,
                (i % 4 == 3) ? 1 : 0, (i == 4) ? 1 : 0, 0);
      tick();
    end
    check_all("run1_done", 0, 2, 0, 0, 0, 0, 1);
    tick();
    check_all("run1_idle", 0, 2, 0, 0, 0, 0, 0);

    // Reset in the middle of a fresh run
    do_start(2'd3, 2'd3, 4'd2);
    tick();
    tick();
    check("midrun.count", 32'(count), 32'd2);
    do_reset();
    check_all("post_reset", 0, 0, 0, 0, 0, 0, 0);

    // Early stop held from start terminates at the first wrap
    early_stop = 1'b1;
    do_start(2'd2, 2'd0, 4'd5);
    for (int i = 0; i < 3; i++) begin
      check_all($sformatf("es_%0d", i), i, 0, 1, (i == 2) ? 1 : 0, (i == 0) ? 1 : 0, 0, 0);
      tick();
    end
    check_all("es_done", 0, 1, 0, 0, 0, 0, 1);
    early_stop = 1'b0;
    tick();

    // Early stop only on a non-wrap cycle is ignored
    do_start(2'd2, 2'd0, 4'd5);
    early_stop = 1'b1;
    tick();
    early_stop = 1'b0;
    check("es2.count1", 32'(count), 32'd1);
    tick();
    tick();
    check_all("es2_wrap", 0, 1, 1, 0, 1, 1, 0);
    do_reset();

    // Hold freezes mid-sweep, and on a wrap cycle it masks early_stop
    do_start(2'd3, 2'd1, 4'd2);
    tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_all($sformatf("hold_%0d", i), 1, 0, 1, 0, 1, 0, 0);
      tick();
    end
    hold = 1'b0;
    check_all("hold_rel", 1, 0, 1, 0, 1, 0, 0);
    tick();
    tick();
    check_all("hold_wrapcyc", 3, 0, 1, 1, 0, 0, 0);
    hold = 1'b1;
    early_stop = 1'b1;
    tick();
    check_all("hold_wrap0", 3, 0, 1, 1, 0, 0, 0);
    tick();
    check_all("hold_wrap1", 3, 0, 1, 1, 0, 0, 0);
    hold = 1'b0;
    early_stop = 1'b0;
    tick();
    check_all("hold_resume", 0, 1, 1, 0, 0, 1, 0);
    tick();
    tick();
    tick();
    check_all("hold_last", 3, 1, 1, 1, 0, 0, 0);
    tick();
    check_all("hold_done", 0, 2, 0, 0, 0, 0, 1);
    tick();

    // Degree one with max_iter zero runs exactly one cycle
    do_start(2'd0, 2'd0, 4'd0);
    check_all("deg1_run", 0, 0, 1, 1, 1, 0, 0);
    tick();
    check_all("deg1_done", 0, 1, 0, 0, 0, 0, 1);
    tick();
    check_all("deg1_idle", 0, 1, 0, 0, 0, 0, 0);

    // Out-of-range min index; start and input changes mid-run are ignored
    do_start(2'd1, 2'd3, 4'd2);
    for (int i = 0; i < 4; i++) begin
      check_all($sformatf("ign_%0d", i), i % 2, i / 2, 1, (i % 2 == 1) ? 1 : 0, 0,
                (i == 2) ? 1 : 0, 0);
      if (i == 1) begin
        start = 1'b1; degree_m1 = 2'd3; min_index = 2'd0; max_iter = 4'd1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check_all("ign_done", 0, 2, 0, 0, 0, 0, 1);
    tick();
    check_all("ign_idle", 0, 2, 0, 0, 0, 0, 0);

    // Wide instance: seven 16-edge sweeps
    p_degree_m1 = 4'd15; p_min_index = 4'd9; p_max_iter = 3'd7; p_start = 1'b1;
    tick();
    p_start = 1'b0;
    usm_cnt = 0;
    idn_cnt = 0;
    for (int i = 0; i < 112; i++) begin
      check($sformatf("wide_count_%0d", i), 32'(p_count), 32'(i % 16));
      if (p_use_second_min) usm_cnt++;
      if (p_iter_done) idn_cnt++;
      tick();
    end
    check("wide.usm_total", 32'(usm_cnt), 32'd7);
    check("wide.iter_done_total", 32'(idn_cnt), 32'd6);
    check("wide.done", 32'(p_done), 32'd1);
    check("wide.iter", 32'(p_iter), 32'd7);
    check("wide.busy", 32'(p_busy), 32'd0);
    tick();
    check("wide.done_pulse", 32'(p_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
